// File: rtl/grid_readout_pkg.sv
// Shared definitions for the grid readout path.
//   readout_state_t : FSM state type of the readout controller
//   num_chunks      : number of output beats per grid word
//   idx_width       : width of the beat index (at least one bit)
//   split_ok        : true when the grid word divides evenly into chunks
package grid_pkg;

    typedef enum logic {IDLE, SEND} readout_state_t;

    function automatic int num_chunks(int data_size, int chunk_size);
        return data_size / chunk_size;
    endfunction

    function automatic int idx_width(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit split_ok(int data_size, int chunk_size);
        return (chunk_size > 0) && (data_size >= chunk_size) &&
               (data_size % chunk_size == 0);
    endfunction

endpackage

// File: rtl/grid_readout_if.sv
// Chunk stream from the grid readout to the host/display side.
//   valid : data/index/last carry a beat
//   ready : sink accepts the current beat
//   data  : chunk payload
//   index : chunk number within the grid word
//   last  : final chunk of the word
interface grid_readout_if #(
    parameter int CHUNK_SIZE = 8,
    parameter int IDX_W      = 3
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [CHUNK_SIZE-1:0] data;
    logic [IDX_W-1:0]      index;

    modport master (output valid, data, index, last, input ready);
    modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/grid_readout_chunk_select.sv
// Combinational chunk picker: returns the index-th CHUNK_SIZE slice of the
// grid word, chunk 0 being the least significant bits.
//   word  : flattened grid word
//   index : chunk number
//   chunk : selected slice
module chunk_select #(
    parameter int DATA_SIZE  = 64,
    parameter int CHUNK_SIZE = 8,
    parameter int IDX_W      = 3
) (
    input  logic [DATA_SIZE-1:0]  word,
    input  logic [IDX_W-1:0]      index,
    output logic [CHUNK_SIZE-1:0] chunk
);

    // A shift keeps the select in range even for the single-chunk build,
    // where the one-bit index could otherwise address past the word.
    assign chunk = CHUNK_SIZE'(word >> (int'(index) * CHUNK_SIZE));

endmodule

// File: rtl/grid_readout.sv
// Grid readout: on start, snapshots the grid word into a shadow register and
// streams it out chunk by chunk over a valid/ready handshake, so the grid
// calculator may keep updating memory during the transfer.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   mem_in : grid word from system memory
//   start  : single-cycle request to snapshot and stream mem_in
//   busy   : transfer in progress
//   done   : one-cycle pulse after the final beat is accepted
//   stream : chunk stream (master side)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no transfer; start captures mem_in and enters SEND
//   SEND  | beat `index` presented; advances on each accepted beat
module grid_readout
    import grid_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int CHUNK_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] mem_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    grid_readout_if.master       stream
);

    localparam int NUM_CHUNKS = num_chunks(DATA_SIZE, CHUNK_SIZE);
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (!split_ok(DATA_SIZE, CHUNK_SIZE)) begin : g_bad_split
        $error("grid_readout: DATA_SIZE must be a multiple of CHUNK_SIZE");
    end

    readout_state_t        state;
    logic [DATA_SIZE-1:0]  shadow;
    logic [IDX_W-1:0]      index;
    logic                  valid_q;
    logic                  last_q;
    logic [CHUNK_SIZE-1:0] chunk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shadow  <= '0;
            index   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow  <= mem_in;
                        index   <= '0;
                        state   <= SEND;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        last_q  <= (LAST_IDX == '0);
                    end
                end
                SEND: begin
                    if (stream.ready) begin
                        if (last_q) begin
                            state   <= IDLE;
                            index   <= '0;
                            valid_q <= 1'b0;
                            busy    <= 1'b0;
                            last_q  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            index  <= index + 1'b1;
                            last_q <= ((index + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    chunk_select #(
        .DATA_SIZE  (DATA_SIZE),
        .CHUNK_SIZE (CHUNK_SIZE),
        .IDX_W      (IDX_W)
    ) u_chunk_select (
        .word  (shadow),
        .index (index),
        .chunk (chunk)
    );

    // Data is forced to zero outside a beat so the bus is quiet when idle.
    assign stream.valid = valid_q;
    assign stream.data  = valid_q ? chunk : '0;
    assign stream.index = index;
    assign stream.last  = last_q;

endmodule

// File: tb/tb_grid_readout.sv
module tb_grid_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] mem_a, mem_b;
    logic        start_a, start_b, ready_a, ready_b;
    logic        busy_a, done_a, busy_b, done_b;

    grid_readout_if #(.CHUNK_SIZE(8),  .IDX_W(3)) sa ();
    grid_readout_if #(.CHUNK_SIZE(64), .IDX_W(1)) sb ();
    assign sa.ready = ready_a;
    assign sb.ready = ready_b;

    grid_readout #(.DATA_SIZE(64), .CHUNK_SIZE(8)) dut_a (
        .clk(clk), .reset(rst_n), .mem_in(mem_a), .start(start_a),
        .busy(busy_a), .done(done_a), .stream(sa));

    grid_readout #(.DATA_SIZE(64), .CHUNK_SIZE(64)) dut_b (
        .clk(clk), .reset(rst_n), .mem_in(mem_b), .start(start_b),
        .busy(busy_b), .done(done_b), .stream(sb));

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a transfer is a queue of the bytes still owed to
    // the sink, filled from the word seen on an accepted start.
    logic [7:0] exp_q[$];
    int         m_idx;
    bit         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_idx  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (exp_q.size() > 0) begin
                if (ready_a) begin
                    void'(exp_q.pop_front());
                    m_idx++;
                    if (exp_q.size() == 0) begin
                        m_idx  = 0;
                        m_done = 1;
                    end
                end
            end else if (start_a) begin
                for (int i = 0; i < 8; i++)
                    exp_q.push_back(8'((mem_a >> (8 * i)) & 64'hFF));
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 64'(sa.valid), 64'(exp_q.size() > 0));
            chk("data",  64'(sa.data),  (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'h0);
            chk("index", 64'(sa.index), (exp_q.size() > 0) ? 64'(m_idx) : 64'h0);
            chk("last",  64'(sa.last),  64'(exp_q.size() == 1));
            chk("busy",  64'(busy_a),   64'(exp_q.size() > 0));
            chk("done",  64'(done_a),   64'(m_done));
        end
    end

    // Beats actually transferred, {last, index, data}, and DONE pulses seen.
    logic [11:0] cap_q[$];
    int          done_cnt;
    always @(negedge clk) begin
        if (sa.valid && ready_a) cap_q.push_back({sa.last, sa.index, sa.data});
        if (done_a) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string name, int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            n = k + 1;
            if (done_a) break;
        end
        chk(name, 64'(done_a), 64'h1);
    endtask

    task automatic check_seq(string name, logic [63:0] bytes_lsb_first);
        logic [7:0] b;
        chk({name, "_beats"}, 64'(cap_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
            b = bytes_lsb_first[8*i +: 8];
            chk({name, "_byte"},  64'(cap_q[i][7:0]),  64'(b));
            chk({name, "_idx"},   64'(cap_q[i][10:8]), 64'(i));
            chk({name, "_lastf"}, 64'(cap_q[i][11]),   64'(i == 7));
        end
    endtask

    int n;

    initial begin
        done_cnt = 0;
        rst_n = 0; start_a = 0; start_b = 0; ready_a = 0; ready_b = 0;
        mem_a = '0; mem_b = '0;
        #1;
        chk("rst_valid", 64'(sa.valid), 64'h0);
        chk("rst_data",  64'(sa.data),  64'h0);
        chk("rst_busy",  64'(busy_a),   64'h0);
        chk("rst_done",  64'(done_a),   64'h0);
        chk("rst_b_valid", 64'(sb.valid), 64'h0);
        repeat (3) step();
        rst_n  = 1;
        cmp_en = 1;

        // Idle with ready wiggling: nothing may happen.
        for (int i = 0; i < 10; i++) begin
            ready_a = i[0];
            step();
        end
        chk("idle_busy", 64'(busy_a), 64'h0);

        // Transfer 1: full-rate.
        mem_a = 64'h0123_4567_89AB_CDEF;
        ready_a = 1; cap_q.delete(); start_a = 1;
        step();
        start_a = 0;
        chk("latency_valid", 64'(sa.valid), 64'h1);
        chk("first_data",    64'(sa.data),  64'hEF);
        wait_done("t1_done", 20, n);
        chk("t1_throughput", 64'(n), 64'd8);
        check_seq("t1", 64'h0123_4567_89AB_CDEF);
        step();

        // Transfer 2: stalls, memory cleared after the snapshot.
        ready_a = 0; cap_q.delete(); start_a = 1;
        step();
        start_a = 0; mem_a = '0;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            ready_a = (k % 4 == 0) || (k % 4 == 3);
            step();
            if (done_a) break;
        end
        chk("t2_done", 64'(done_a), 64'h1);
        check_seq("t2", 64'h0123_4567_89AB_CDEF);
        step();

        // Transfer 3: start during beat 3 and the final handshake is ignored;
        // start on the DONE cycle launches a new transfer.
        mem_a = 64'hFEDC_BA98_7654_3210;
        ready_a = 1; done_cnt = 0; start_a = 1;
        step();
        for (int k = 0; k < 8; k++) begin
            start_a = (k == 3) || (k == 7);
            step();
        end
        chk("t3_done_now", 64'(done_a), 64'h1);
        start_a = 1;
        step();
        start_a = 0;
        chk("t3_one_done",     64'(done_cnt), 64'd1);
        chk("restart_valid",   64'(sa.valid), 64'h1);
        chk("restart_index",   64'(sa.index), 64'h0);
        chk("restart_data",    64'(sa.data),  64'h10);
        wait_done("t3b_done", 20, n);
        step();

        // Transfer 4: asynchronous reset in the middle of beat 4.
        mem_a = 64'h1122_3344_5566_7788;
        start_a = 1;
        step();
        start_a = 0;
        repeat (4) step();
        chk("pre_rst_index", 64'(sa.index), 64'd4);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 64'(sa.valid), 64'h0);
        chk("arst_data",  64'(sa.data),  64'h0);
        chk("arst_index", 64'(sa.index), 64'h0);
        chk("arst_last",  64'(sa.last),  64'h0);
        chk("arst_busy",  64'(busy_a),   64'h0);
        done_cnt = 0;
        repeat (2) step();
        rst_n = 1;
        step();
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        start_a = 1;
        step();
        start_a = 0;
        chk("post_rst_index", 64'(sa.index), 64'h0);
        chk("post_rst_data",  64'(sa.data),  64'h88);
        wait_done("t4_done", 20, n);
        step();

        // Single-chunk build.
        mem_b = 64'hDEAD_BEEF_0000_0001;
        ready_b = 1; start_b = 1;
        step();
        start_b = 0;
        chk("b_valid", 64'(sb.valid), 64'h1);
        chk("b_last",  64'(sb.last),  64'h1);
        chk("b_index", 64'(sb.index), 64'h0);
        chk("b_data",  64'(sb.data),  64'hDEAD_BEEF_0000_0001);
        chk("b_busy",  64'(busy_b),   64'h1);
        chk("b_nodone", 64'(done_b),  64'h0);
        step();
        chk("b_valid_off", 64'(sb.valid), 64'h0);
        chk("b_data_off",  64'(sb.data),  64'h0);
        chk("b_done",      64'(done_b),   64'h1);
        chk("b_busy_off",  64'(busy_b),   64'h0);
        step();
        chk("b_done_pulse", 64'(done_b), 64'h0);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
